// File: rtl/snum_disp_ctrl.sv
// rtl/snum_disp_ctrl.sv - signed 8-bit to seven-segment converter, one decimal digit per clock
// Optional time-multiplexed scan outputs are enabled with SNUM_DISP_SCAN_EN.
module snum_disp_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_data,
    output logic [7*NUM_DIGITS-1:0] segs,
`ifdef SNUM_DISP_SCAN_EN
    output logic [NUM_DIGITS-1:0]   scan_an,
    output logic [6:0]              scan_seg,
`endif
    output logic                    busy,
    output logic                    done
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] MINUS = 7'h3F;

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_SIGN, S_COMMIT} state_t;

    state_t                  state;
    logic                    neg;
    logic [8:0]              mag;
    logic [8:0]              mag_next;
    logic [IW-1:0]           idx;
    logic [7*NUM_DIGITS-1:0] shadow;

    function automatic logic [6:0] seg_code(input logic [8:0] d);
        case (d)
            9'd0:    seg_code = 7'h40;
            9'd1:    seg_code = 7'h79;
            9'd2:    seg_code = 7'h24;
            9'd3:    seg_code = 7'h30;
            9'd4:    seg_code = 7'h19;
            9'd5:    seg_code = 7'h12;
            9'd6:    seg_code = 7'h02;
            9'd7:    seg_code = 7'h78;
            9'd8:    seg_code = 7'h00;
            9'd9:    seg_code = 7'h10;
            default: seg_code = BLANK;
        endcase
    endfunction

    assign mag_next = mag / 9'd10;

    // The shadow image is built digit by digit; segs only changes in COMMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            neg      <= 1'b0;
            mag      <= '0;
            idx      <= '0;
            shadow   <= {NUM_DIGITS{BLANK}};
            segs     <= {NUM_DIGITS{BLANK}};
            in_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        neg      <= in_data[7];
                        mag      <= in_data[7] ? (9'd0 - {1'b1, in_data}) : {1'b0, in_data};
                        shadow   <= {NUM_DIGITS{BLANK}};
                        idx      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_CONV;
                    end
                end
                S_CONV: begin
                    for (int k = 0; k < NUM_DIGITS; k++) begin
                        if (IW'(k) == idx) shadow[7*k +: 7] <= seg_code(mag % 9'd10);
                    end
                    mag <= mag_next;
                    idx <= idx + IW'(1);
                    if (mag_next == 9'd0) begin
                        if (neg) begin
                            state <= S_SIGN;
                        end else begin
                            busy  <= 1'b0;
                            state <= S_COMMIT;
                        end
                    end
                end
                S_SIGN: begin
                    for (int k = 0; k < NUM_DIGITS; k++) begin
                        if (IW'(k) == idx) shadow[7*k +: 7] <= MINUS;
                    end
                    busy  <= 1'b0;
                    state <= S_COMMIT;
                end
                S_COMMIT: begin
                    segs     <= shadow;
                    done     <= 1'b1;
                    in_ready <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SNUM_DISP_SCAN_EN
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DW-1:0] div_cnt;
    logic [IW-1:0] slot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            slot    <= '0;
            scan_an <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
        end else if (div_cnt == DW'(SCAN_DIV - 1)) begin
            div_cnt <= '0;
            scan_an <= {scan_an[NUM_DIGITS-2:0], scan_an[NUM_DIGITS-1]};
            slot    <= (slot == IW'(NUM_DIGITS - 1)) ? '0 : slot + IW'(1);
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // Reads the committed image, so the scan never shows a half-built value.
    always_comb begin
        scan_seg = BLANK;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (IW'(k) == slot) scan_seg = segs[7*k +: 7];
        end
    end
`else
    if (SCAN_DIV < 1) begin : g_scan_div_invalid
    end
`endif

endmodule
